// File: rtl/fx_pkg.sv
// Shared constants and types for the fx register-bus arbiter.
package fx_pkg;

  localparam int FX_AW = 22;
  localparam int FX_DW = 8;
  localparam int ID_W  = 1;

  typedef logic [ID_W-1:0] id_t;

  localparam id_t ID_M0 = 1'b0;
  localparam id_t ID_M1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/fx_arb_rr.sv
// Two-way round-robin picker: on a tie the master that was not served last wins.
module fx_arb_rr
  import fx_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_served,
  output logic       pick,
  output logic       pick_vld
);

  always_comb begin
    pick_vld = |req;
    if (&req) begin
      pick = ~last_served;
    end else begin
      pick = req[1] ? ID_M1 : ID_M0;
    end
  end

endmodule

// File: rtl/fx_arb.sv
// Two-master round-robin arbiter for the fx register bus, with hold-time limit
// and a tagged read-return path.
module fx_arb
  import fx_pkg::*;
#(
  parameter int AW       = FX_AW,
  parameter int DW       = FX_DW,
  parameter int MAX_HOLD = 4096
) (
  input  logic          clk_sys,
  input  logic          rst_n,

  input  logic          m0_req,
  output logic          m0_gnt,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_waddr,
  input  logic [DW-1:0] m0_data,
  input  logic          m0_rd,
  input  logic [AW-1:0] m0_raddr,
  output logic [DW-1:0] m0_q,
  output logic          m0_qv,

  input  logic          m1_req,
  output logic          m1_gnt,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_waddr,
  input  logic [DW-1:0] m1_data,
  input  logic          m1_rd,
  input  logic [AW-1:0] m1_raddr,
  output logic [DW-1:0] m1_q,
  output logic          m1_qv,

  output logic          fx_wr,
  output logic [AW-1:0] fx_waddr,
  output logic [DW-1:0] fx_data,
  output logic          fx_rd,
  output logic [AW-1:0] fx_raddr,
  input  logic [DW-1:0] fx_q,

  output logic          arb_tmo,
  output logic          arb_ill
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_TOP = (MAX_HOLD > 1) ? CW'(MAX_HOLD - 1) : '0;

  state_t        state, state_nxt;
  id_t           owner, owner_nxt;
  logic          last_served, last_nxt;
  logic [CW-1:0] hold_cnt, hold_nxt;

  logic          pick, pick_vld;
  logic          own_req, oth_req, own_wr, own_rd;
  logic [AW-1:0] own_waddr, own_raddr;
  logic [DW-1:0] own_data;
  logic          in_own, tmo_hit, accept, ill;

  logic          rd_vld_p0, rd_vld_p1;
  id_t           rd_id_p0, rd_id_p1;

  fx_arb_rr u_rr (
    .req         ({m1_req, m0_req}),
    .last_served (last_served),
    .pick        (pick),
    .pick_vld    (pick_vld)
  );

  always_comb begin
    own_req   = (owner == ID_M1) ? m1_req   : m0_req;
    oth_req   = (owner == ID_M1) ? m0_req   : m1_req;
    own_wr    = (owner == ID_M1) ? m1_wr    : m0_wr;
    own_rd    = (owner == ID_M1) ? m1_rd    : m0_rd;
    own_waddr = (owner == ID_M1) ? m1_waddr : m0_waddr;
    own_data  = (owner == ID_M1) ? m1_data  : m0_data;
    own_raddr = (owner == ID_M1) ? m1_raddr : m0_raddr;

    in_own  = (state == ST_OWN);
    // A voluntary release in the same cycle takes precedence over revocation.
    tmo_hit = in_own && own_req && (MAX_HOLD != 0) && (hold_cnt == HOLD_TOP) && oth_req;
    accept  = in_own && !tmo_hit;
    ill     = ((m0_wr || m0_rd) && !(in_own && owner == ID_M0)) ||
              ((m1_wr || m1_rd) && !(in_own && owner == ID_M1));

    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_served;
    hold_nxt  = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          state_nxt = ST_OWN;
          owner_nxt = pick;
          last_nxt  = pick;
          hold_nxt  = '0;
        end
      end
      ST_OWN: begin
        if (!own_req || tmo_hit) begin
          state_nxt = ST_DRAIN;
        end else if (hold_cnt != HOLD_TOP) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!rd_vld_p0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      owner       <= ID_M0;
      last_served <= 1'b1;
      hold_cnt    <= '0;
      arb_tmo     <= 1'b0;
      arb_ill     <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_served <= last_nxt;
      hold_cnt    <= hold_nxt;
      arb_tmo     <= tmo_hit;
      arb_ill     <= ill;
    end
  end

  // p0: accepted owner beat registered onto the slave bus, tagged with its master.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      fx_wr     <= 1'b0;
      fx_rd     <= 1'b0;
      fx_waddr  <= '0;
      fx_data   <= '0;
      fx_raddr  <= '0;
      rd_vld_p0 <= 1'b0;
      rd_id_p0  <= ID_M0;
      rd_vld_p1 <= 1'b0;
      rd_id_p1  <= ID_M0;
    end else begin
      fx_wr     <= accept && own_wr;
      fx_rd     <= accept && own_rd;
      fx_waddr  <= (accept && own_wr) ? own_waddr : '0;
      fx_data   <= (accept && own_wr) ? own_data  : '0;
      fx_raddr  <= (accept && own_rd) ? own_raddr : '0;
      rd_vld_p0 <= accept && own_rd;
      rd_id_p0  <= owner;
      // p1: tag aligned with the cycle in which the slave presents fx_q.
      rd_vld_p1 <= rd_vld_p0;
      rd_id_p1  <= rd_id_p0;
    end
  end

  assign m0_gnt = in_own && (owner == ID_M0);
  assign m1_gnt = in_own && (owner == ID_M1);
  assign m0_qv  = rd_vld_p1 && (rd_id_p1 == ID_M0);
  assign m1_qv  = rd_vld_p1 && (rd_id_p1 == ID_M1);
  assign m0_q   = m0_qv ? fx_q : '0;
  assign m1_q   = m1_qv ? fx_q : '0;

endmodule

// File: tb/tb_fx_arb.sv
// Directed bench for fx_arb: grant order, forwarding, read tagging, hold limit and reset.
module tb_fx_arb;

  localparam int AW = 22;
  localparam int DW = 8;

  logic          clk_sys = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_gnt, m0_wr, m0_rd, m0_qv;
  logic [AW-1:0] m0_waddr, m0_raddr;
  logic [DW-1:0] m0_data, m0_q;
  logic          m1_req, m1_gnt, m1_wr, m1_rd, m1_qv;
  logic [AW-1:0] m1_waddr, m1_raddr;
  logic [DW-1:0] m1_data, m1_q;
  logic          fx_wr, fx_rd;
  logic [AW-1:0] fx_waddr, fx_raddr;
  logic [DW-1:0] fx_data, fx_q;
  logic          arb_tmo, arb_ill;

  int checks   = 0;
  int failures = 0;

  fx_arb #(.AW(AW), .DW(DW), .MAX_HOLD(8)) dut (
    .clk_sys  (clk_sys),  .rst_n    (rst_n),
    .m0_req   (m0_req),   .m0_gnt   (m0_gnt),   .m0_wr    (m0_wr),
    .m0_waddr (m0_waddr), .m0_data  (m0_data),  .m0_rd    (m0_rd),
    .m0_raddr (m0_raddr), .m0_q     (m0_q),     .m0_qv    (m0_qv),
    .m1_req   (m1_req),   .m1_gnt   (m1_gnt),   .m1_wr    (m1_wr),
    .m1_waddr (m1_waddr), .m1_data  (m1_data),  .m1_rd    (m1_rd),
    .m1_raddr (m1_raddr), .m1_q     (m1_q),     .m1_qv    (m1_qv),
    .fx_wr    (fx_wr),    .fx_waddr (fx_waddr), .fx_data  (fx_data),
    .fx_rd    (fx_rd),    .fx_raddr (fx_raddr), .fx_q     (fx_q),
    .arb_tmo  (arb_tmo),  .arb_ill  (arb_ill)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_wr = 0; m0_rd = 0; m0_waddr = '0; m0_raddr = '0; m0_data = '0;
    m1_req = 0; m1_wr = 0; m1_rd = 0; m1_waddr = '0; m1_raddr = '0; m1_data = '0;
    fx_q = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] ctl;
    clear_inputs();
    rst_n = 0;
    tick();
    ctl = {m0_gnt, m1_gnt, m0_qv, m1_qv, fx_wr, fx_rd, arb_tmo, arb_ill};
    checks++;
    if (ctl !== 8'h00) begin
      failures++; $display("FAIL reset_ctl: got %b expected 00000000", ctl);
    end
    checks++;
    if ({fx_waddr, fx_raddr, fx_data, m0_q, m1_q} !== '0) begin
      failures++; $display("FAIL reset_bus: waddr=%h raddr=%h data=%h expected 0", fx_waddr, fx_raddr, fx_data);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_single_grant();
    apply_reset();
    m0_req = 1;
    tick();
    checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      failures++; $display("FAIL single_gnt: m0_gnt=%b m1_gnt=%b expected 1 0", m0_gnt, m1_gnt);
    end
    m0_wr = 1; m0_waddr = 22'h000010; m0_data = 8'h5A;
    tick();
    checks++;
    if (fx_wr !== 1'b1 || fx_waddr !== 22'h000010 || fx_data !== 8'h5A || m1_gnt !== 1'b0) begin
      failures++; $display("FAIL single_wr: fx_wr=%b waddr=%h data=%h m1_gnt=%b expected 1 000010 5a 0",
                           fx_wr, fx_waddr, fx_data, m1_gnt);
    end
    m0_wr = 0; m0_req = 0;
    tick();
    checks++;
    if (fx_wr !== 1'b0 || m0_gnt !== 1'b0) begin
      failures++; $display("FAIL single_release: fx_wr=%b m0_gnt=%b expected 0 0", fx_wr, m0_gnt);
    end
    tick(); tick();
  endtask

  task automatic test_tie_round_robin();
    apply_reset();
    m0_req = 1; m1_req = 1;
    tick();
    checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      failures++; $display("FAIL tie_first: m0_gnt=%b m1_gnt=%b expected 1 0", m0_gnt, m1_gnt);
    end
    tick();
    m0_req = 0;
    tick();
    checks++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      failures++; $display("FAIL tie_drain_gap: m0_gnt=%b m1_gnt=%b expected 0 0", m0_gnt, m1_gnt);
    end
    tick();
    checks++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      failures++; $display("FAIL tie_idle_gap: m0_gnt=%b m1_gnt=%b expected 0 0", m0_gnt, m1_gnt);
    end
    tick();
    checks++;
    if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
      failures++; $display("FAIL tie_second: m1_gnt=%b m0_gnt=%b expected 1 0", m1_gnt, m0_gnt);
    end
    m1_req = 0;
    tick();
    tick();
    m0_req = 1; m1_req = 1;
    tick();
    checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      failures++; $display("FAIL tie_rerequest: m0_gnt=%b m1_gnt=%b expected 1 0", m0_gnt, m1_gnt);
    end
    m0_req = 0; m1_req = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_back_to_back_read();
    apply_reset();
    m1_req = 1;
    tick();
    m1_rd = 1; m1_raddr = 22'h000020;
    tick();
    checks++;
    if (fx_rd !== 1'b1 || fx_raddr !== 22'h000020) begin
      failures++; $display("FAIL b2b_rd0: fx_rd=%b raddr=%h expected 1 000020", fx_rd, fx_raddr);
    end
    m1_raddr = 22'h000021;
    tick();
    fx_q = 8'h11;
    #1;
    checks++;
    if (m1_qv !== 1'b1 || m1_q !== 8'h11 || m0_qv !== 1'b0 || fx_raddr !== 22'h000021) begin
      failures++; $display("FAIL b2b_q0: m1_qv=%b m1_q=%h m0_qv=%b raddr=%h expected 1 11 0 000021",
                           m1_qv, m1_q, m0_qv, fx_raddr);
    end
    m1_raddr = 22'h000022;
    tick();
    fx_q = 8'h22;
    #1;
    checks++;
    if (m1_qv !== 1'b1 || m1_q !== 8'h22 || m0_qv !== 1'b0 || fx_raddr !== 22'h000022) begin
      failures++; $display("FAIL b2b_q1: m1_qv=%b m1_q=%h m0_qv=%b raddr=%h expected 1 22 0 000022",
                           m1_qv, m1_q, m0_qv, fx_raddr);
    end
    m1_rd = 0;
    tick();
    fx_q = 8'h33;
    #1;
    checks++;
    if (m1_qv !== 1'b1 || m1_q !== 8'h33 || m0_qv !== 1'b0 || fx_rd !== 1'b0) begin
      failures++; $display("FAIL b2b_q2: m1_qv=%b m1_q=%h m0_qv=%b fx_rd=%b expected 1 33 0 0",
                           m1_qv, m1_q, m0_qv, fx_rd);
    end
    tick();
    checks++;
    if (m1_qv !== 1'b0 || m0_qv !== 1'b0) begin
      failures++; $display("FAIL b2b_end: m1_qv=%b m0_qv=%b expected 0 0", m1_qv, m0_qv);
    end
    fx_q = '0; m1_req = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_read_on_release();
    apply_reset();
    m1_req = 1;
    tick();
    m1_req = 0; m1_rd = 1; m1_raddr = 22'h000030;
    tick();
    checks++;
    if (m1_gnt !== 1'b0 || fx_rd !== 1'b1 || fx_raddr !== 22'h000030) begin
      failures++; $display("FAIL rel_rd_fwd: m1_gnt=%b fx_rd=%b raddr=%h expected 0 1 000030",
                           m1_gnt, fx_rd, fx_raddr);
    end
    m1_rd = 0; m0_req = 1;
    tick();
    fx_q = 8'h77;
    #1;
    checks++;
    if (m1_qv !== 1'b1 || m1_q !== 8'h77 || m0_gnt !== 1'b0) begin
      failures++; $display("FAIL rel_rd_return: m1_qv=%b m1_q=%h m0_gnt=%b expected 1 77 0", m1_qv, m1_q, m0_gnt);
    end
    tick();
    checks++;
    if (m0_gnt !== 1'b0 || m1_qv !== 1'b0) begin
      failures++; $display("FAIL rel_idle_gap: m0_gnt=%b m1_qv=%b expected 0 0", m0_gnt, m1_qv);
    end
    tick();
    checks++;
    if (m0_gnt !== 1'b1) begin
      failures++; $display("FAIL rel_next_gnt: m0_gnt=%b expected 1", m0_gnt);
    end
    m0_req = 0; fx_q = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_max_hold();
    int bad;
    apply_reset();
    m0_req = 1; m1_req = 1;
    tick();
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        m0_wr = 1; m0_waddr = 22'h000099; m0_data = 8'hEE;
      end
      if (m0_gnt !== 1'b1 || arb_tmo !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL hold_own_cycles: bad=%0d expected 0", bad);
    end
    checks++;
    if (m0_gnt !== 1'b0 || arb_tmo !== 1'b1 || fx_wr !== 1'b0 || arb_ill !== 1'b0) begin
      failures++; $display("FAIL hold_revoke: m0_gnt=%b tmo=%b fx_wr=%b ill=%b expected 0 1 0 0",
                           m0_gnt, arb_tmo, fx_wr, arb_ill);
    end
    m0_wr = 0;
    tick();
    checks++;
    if (arb_tmo !== 1'b0) begin
      failures++; $display("FAIL hold_tmo_once: tmo=%b expected 0", arb_tmo);
    end
    tick();
    checks++;
    if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
      failures++; $display("FAIL hold_handover: m1_gnt=%b m0_gnt=%b expected 1 0", m1_gnt, m0_gnt);
    end
    m0_req = 0; m1_req = 0;
    tick(); tick(); tick();
    m0_req = 1;
    tick();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (m0_gnt !== 1'b1 || arb_tmo !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL hold_unlimited: bad=%0d expected 0", bad);
    end
    m1_req = 1;
    tick();
    checks++;
    if (m0_gnt !== 1'b0 || arb_tmo !== 1'b1) begin
      failures++; $display("FAIL hold_saturated: m0_gnt=%b tmo=%b expected 0 1", m0_gnt, arb_tmo);
    end
    m0_req = 0; m1_req = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_illegal_and_reset();
    int bad;
    apply_reset();
    m0_req = 1;
    tick();
    m1_wr = 1; m1_waddr = 22'h000044; m1_data = 8'h12;
    tick();
    checks++;
    if (fx_wr !== 1'b0 || arb_ill !== 1'b1 || m0_gnt !== 1'b1) begin
      failures++; $display("FAIL ill_pulse: fx_wr=%b ill=%b m0_gnt=%b expected 0 1 1", fx_wr, arb_ill, m0_gnt);
    end
    m1_wr = 0;
    tick();
    checks++;
    if (arb_ill !== 1'b0) begin
      failures++; $display("FAIL ill_once: ill=%b expected 0", arb_ill);
    end
    m0_rd = 1; m0_raddr = 22'h000050;
    tick();
    checks++;
    if (fx_rd !== 1'b1 || fx_raddr !== 22'h000050) begin
      failures++; $display("FAIL mid_rd_issue: fx_rd=%b raddr=%h expected 1 000050", fx_rd, fx_raddr);
    end
    m0_rd = 0;
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, fx_rd, fx_wr, m0_qv, m1_qv, arb_tmo, arb_ill} !== 8'h00 || fx_raddr !== '0) begin
      failures++; $display("FAIL mid_reset_outputs: gnt=%b%b fx_rd=%b qv=%b%b raddr=%h expected all 0",
                           m0_gnt, m1_gnt, fx_rd, m0_qv, m1_qv, fx_raddr);
    end
    fx_q = 8'hAA; m0_req = 0;
    tick(); tick();
    rst_n = 1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (m0_qv !== 1'b0 || m1_qv !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL mid_reset_no_qv: bad=%0d expected 0", bad);
    end
    fx_q = '0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_single_grant();
    test_tie_round_robin();
    test_back_to_back_read();
    test_read_on_release();
    test_max_hold();
    test_illegal_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
